// File: rtl/uop_pkg.sv
// Shared encodings for the microprogram sequencer: opcodes, micro-word field
// positions and FSM states.
package uop_pkg;

  localparam int WORD_W = 24;

  localparam logic [2:0] OP_EXEC = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BZ   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  localparam int OP_MSB   = 23;
  localparam int OP_LSB   = 21;
  localparam int DSEL_MSB = 20;
  localparam int DSEL_LSB = 18;
  localparam int ASEL_MSB = 17;
  localparam int ASEL_LSB = 15;
  localparam int BSEL_MSB = 14;
  localparam int BSEL_LSB = 12;
  localparam int ALU_MSB  = 11;
  localparam int ALU_LSB  = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  // Opcodes 6 and 7 are unassigned and behave as plain EXEC.
  function automatic logic is_exec_class(input logic [2:0] op);
    return !(op inside {OP_JMP, OP_BZ, OP_CALL, OP_RET, OP_HALT});
  endfunction

endpackage

// File: rtl/uop_store.sv
// Microcode store: single write port, synchronous read with one cycle of latency.
module uop_store #(
  parameter int AW = 8,
  parameter int DW = 24
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uop_sequencer.sv
// Microprogram sequencer feeding regFile selects, ALU op and an immediate.
// Each micro-op takes a FETCH cycle followed by an EXEC cycle.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int AW   = 8,
  parameter int SDEP = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          UWE,
  input  logic [AW-1:0] UADDR,
  input  logic [23:0]   UDATA,
  input  logic          START,
  input  logic [AW-1:0] START_ADDR,
  input  logic          ZIN,
  output logic [2:0]    ASEL,
  output logic [2:0]    BSEL,
  output logic [2:0]    DSEL,
  output logic [15:0]   DIN,
  output logic [3:0]    ALUOP,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  localparam int SPW = $clog2(SDEP + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     upc_q, upc_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              zreg_q, zreg_d;
  logic              err_q, err_d;
  logic [AW-1:0]     stack_q [SDEP];
  logic [AW-1:0]     upc_inc;
  logic [AW-1:0]     ret_addr;
  logic [AW-1:0]     imm_addr;
  logic [WORD_W-1:0] word;
  logic [2:0]        op;
  logic              push;
  logic              done_c;

  uop_store #(.AW(AW), .DW(WORD_W)) u_store (
    .clk_i   (CLK),
    .we_i    (UWE && (state_q == ST_IDLE)),
    .waddr_i (UADDR),
    .wdata_i (UDATA),
    .raddr_i (upc_q),
    .rdata_o (word)
  );

  assign op       = word[OP_MSB:OP_LSB];
  assign upc_inc  = upc_q + AW'(1);
  assign imm_addr = AW'(word[IMM_MSB:IMM_LSB]);

  always_comb begin
    ret_addr = '0;
    for (int i = 0; i < SDEP; i++) begin
      if (sp_q == SPW'(i + 1)) ret_addr = stack_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    sp_d    = sp_q;
    zreg_d  = zreg_q;
    err_d   = err_q;
    push    = 1'b0;
    done_c  = 1'b0;
    ASEL    = '0;
    BSEL    = '0;
    DSEL    = '0;
    DIN     = '0;
    ALUOP   = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A new program also starts with an empty return stack.
        if (START) begin
          upc_d   = START_ADDR;
          err_d   = 1'b0;
          sp_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        upc_d   = upc_inc;
        if (is_exec_class(op)) begin
          DSEL   = word[DSEL_MSB:DSEL_LSB];
          ASEL   = word[ASEL_MSB:ASEL_LSB];
          BSEL   = word[BSEL_MSB:BSEL_LSB];
          ALUOP  = word[ALU_MSB:ALU_LSB];
          DIN    = {8'h00, word[IMM_MSB:IMM_LSB]};
          zreg_d = ZIN;
        end else begin
          unique case (op)
            OP_JMP: upc_d = imm_addr;
            OP_BZ:  if (zreg_q) upc_d = imm_addr;
            OP_CALL: begin
              if (sp_q == SPW'(SDEP)) begin
                err_d   = 1'b1;
                done_c  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                push  = 1'b1;
                sp_d  = sp_q + SPW'(1);
                upc_d = imm_addr;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                err_d   = 1'b1;
                done_c  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                sp_d  = sp_q - SPW'(1);
                upc_d = ret_addr;
              end
            end
            default: begin
              done_c  = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      sp_q    <= '0;
      zreg_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      sp_q    <= sp_d;
      zreg_q  <= zreg_d;
      err_q   <= err_d;
    end
  end

  // Stack entries carry no reset; sp_q alone defines which are live.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < SDEP; i++) begin
      if (push && (sp_q == SPW'(i))) stack_q[i] <= upc_inc;
    end
  end

  assign DONE = done_c;
  assign BUSY = (state_q != ST_IDLE) && !done_c;
  assign ERR  = err_q;

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer: directed programs push expected output
// events (relative cycle + outputs); a negedge monitor pops and compares them.
module tb_uop_sequencer;
  import uop_pkg::*;

  logic        clk = 1'b0;
  logic        RST, UWE, START, ZIN;
  logic [7:0]  UADDR, START_ADDR;
  logic [23:0] UDATA;
  logic [2:0]  ASEL, BSEL, DSEL;
  logic [15:0] DIN;
  logic [3:0]  ALUOP;
  logic        BUSY, DONE, ERR;
  logic [31:0] outs;

  typedef struct {
    int          rel;
    logic        done;
    logic [2:0]  d, a, b;
    logic [3:0]  alu;
    logic [15:0] din;
    logic        busy;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  done_cnt = 0;

  uop_sequencer #(.AW(8), .SDEP(4)) dut (
    .CLK(clk), .RST(RST), .UWE(UWE), .UADDR(UADDR), .UDATA(UDATA),
    .START(START), .START_ADDR(START_ADDR), .ZIN(ZIN),
    .ASEL(ASEL), .BSEL(BSEL), .DSEL(DSEL), .DIN(DIN), .ALUOP(ALUOP),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  assign outs = {ASEL, BSEL, DSEL, DIN, ALUOP, BUSY, DONE, ERR};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] w(input logic [2:0] op, input logic [2:0] d,
                                    input logic [2:0] a, input logic [2:0] b,
                                    input logic [3:0] alu, input logic [7:0] imm);
    return {op, d, a, b, alu, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  task automatic exp_ev(input int rel, input logic [2:0] d, input logic [2:0] a,
                        input logic [2:0] b, input logic [3:0] alu, input logic [15:0] din);
    exp_q.push_back('{rel, 1'b0, d, a, b, alu, din, 1'b1});
  endtask

  task automatic exp_done(input int rel);
    exp_q.push_back('{rel, 1'b1, 3'd0, 3'd0, 3'd0, 4'd0, 16'd0, 1'b0});
  endtask

  task automatic load(input logic [7:0] addr, input logic [23:0] data);
    UWE = 1'b1; UADDR = addr; UDATA = data;
    tick();
    UWE = 1'b0;
  endtask

  task automatic start(input logic [7:0] addr);
    START = 1'b1; START_ADDR = addr; start_cyc = cyc;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no DONE within %0d cycles", name, budget);
    end
  endtask

  task automatic chk_q(input string name);
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Monitor: any cycle with a nonzero select/op/imm or DONE is an output event.
  always @(negedge clk) begin
    if (!RST && (DONE || DSEL != 0 || ASEL != 0 || BSEL != 0 || ALUOP != 0 || DIN != 0)) begin
      automatic int rel = cyc - start_cyc;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: rel=%0d done=%0b d=%0d a=%0d b=%0d alu=%0h din=%0h, none required",
                 rel, DONE, DSEL, ASEL, BSEL, ALUOP, DIN);
      end else begin
        automatic ev_t e = exp_q.pop_front();
        if (rel != e.rel || DONE !== e.done || DSEL !== e.d || ASEL !== e.a ||
            BSEL !== e.b || ALUOP !== e.alu || DIN !== e.din || BUSY !== e.busy) begin
          n_bad++;
          $display("FAIL event: got rel=%0d done=%0b d=%0d a=%0d b=%0d alu=%0h din=%0h busy=%0b want rel=%0d done=%0b d=%0d a=%0d b=%0d alu=%0h din=%0h busy=%0b",
                   rel, DONE, DSEL, ASEL, BSEL, ALUOP, DIN, BUSY,
                   e.rel, e.done, e.d, e.a, e.b, e.alu, e.din, e.busy);
        end else begin
          $display("ok   event rel=%0d done=%0b d=%0d a=%0d b=%0d alu=%0h din=%0h",
                   rel, DONE, DSEL, ASEL, BSEL, ALUOP, DIN);
        end
      end
      if (DONE) done_cnt++;
    end
  end

  initial begin
    #500000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    RST = 1'b1; UWE = 1'b0; START = 1'b0; ZIN = 1'b0;
    UADDR = '0; START_ADDR = '0; UDATA = '0;
    tick(); tick(); tick();
    chk("reset_outs", outs, 32'd0);
    RST = 1'b0;
    tick();
    chk("idle_outs", outs, 32'd0);

    // Single EXEC then HALT; DONE lands 4 cycles after START.
    load(8'd0, w(OP_EXEC, 3'd1, 3'd0, 3'd2, 4'h3, 8'd5));
    load(8'd1, w(OP_HALT, 3'd0, 3'd0, 3'd0, 4'h0, 8'd0));
    exp_ev(2, 3'd1, 3'd0, 3'd2, 4'h3, 16'h0005);
    exp_done(4);
    start(8'd0);
    wait_done("t1", 20);
    chk("t1_err", 32'(ERR), 32'd0);
    chk("t1_busy_after", 32'(BUSY), 32'd0);
    chk_q("t1");

    // Branch on zero: taken goes to @10, not taken falls to @2 (opcode 6 = EXEC).
    load(8'd0,  w(OP_EXEC, 3'd2, 3'd1, 3'd3, 4'h1, 8'h11));
    load(8'd1,  w(OP_BZ,   3'd7, 3'd7, 3'd7, 4'hF, 8'd10));
    load(8'd2,  w(3'd6,    3'd4, 3'd0, 3'd0, 4'h0, 8'h20));
    load(8'd3,  w(OP_HALT, 3'd0, 3'd0, 3'd0, 4'h0, 8'd0));
    load(8'd10, w(OP_EXEC, 3'd3, 3'd0, 3'd0, 4'h0, 8'hA0));
    load(8'd11, w(OP_HALT, 3'd0, 3'd0, 3'd0, 4'h0, 8'd0));
    ZIN = 1'b1;
    exp_ev(2, 3'd2, 3'd1, 3'd3, 4'h1, 16'h0011);
    exp_ev(6, 3'd3, 3'd0, 3'd0, 4'h0, 16'h00A0);
    exp_done(8);
    start(8'd0);
    wait_done("t2_taken", 30);
    chk_q("t2_taken");
    ZIN = 1'b0;
    exp_ev(2, 3'd2, 3'd1, 3'd3, 4'h1, 16'h0011);
    exp_ev(6, 3'd4, 3'd0, 3'd0, 4'h0, 16'h0020);
    exp_done(8);
    start(8'd0);
    wait_done("t2_fall", 30);
    chk_q("t2_fall");

    // CALL/RET: 0 -> 20 -> 1 (HALT).
    load(8'd0,  w(OP_CALL, 3'd1, 3'd1, 3'd1, 4'h1, 8'd20));
    load(8'd20, w(OP_RET,  3'd2, 3'd2, 3'd2, 4'h2, 8'd0));
    load(8'd1,  w(OP_HALT, 3'd0, 3'd0, 3'd0, 4'h0, 8'd0));
    exp_done(6);
    start(8'd0);
    wait_done("t3", 30);
    chk("t3_err", 32'(ERR), 32'd0);
    chk_q("t3");

    // Recursive CALL overflows on the fifth call.
    load(8'd30, w(OP_CALL, 3'd0, 3'd0, 3'd0, 4'h0, 8'd30));
    exp_done(10);
    start(8'd30);
    wait_done("t4_ovf", 40);
    chk("t4_ovf_err", 32'(ERR), 32'd1);
    chk("t4_ovf_busy", 32'(BUSY), 32'd0);
    chk_q("t4_ovf");

    // RET on an empty stack; a second START clears ERR before it sets again.
    do_reset();
    chk("t4_rst_err", 32'(ERR), 32'd0);
    load(8'd40, w(OP_RET, 3'd0, 3'd0, 3'd0, 4'h0, 8'd0));
    exp_done(2);
    start(8'd40);
    wait_done("t4_unf", 20);
    chk("t4_unf_err", 32'(ERR), 32'd1);
    exp_done(2);
    start(8'd40);
    chk("t4_start_clr_err", 32'(ERR), 32'd0);
    wait_done("t4_unf2", 20);
    chk("t4_unf2_err", 32'(ERR), 32'd1);
    chk_q("t4_unf");

    // Wrap 255 -> 0; START and UWE while busy are ignored (opcode 7 = EXEC).
    load(8'd255, w(3'd7,    3'd6, 3'd1, 3'd2, 4'h9, 8'h55));
    load(8'd0,   w(OP_HALT, 3'd0, 3'd0, 3'd0, 4'h0, 8'd0));
    exp_ev(2, 3'd6, 3'd1, 3'd2, 4'h9, 16'h0055);
    exp_done(4);
    start(8'd255);
    chk("t5_busy", 32'(BUSY), 32'd1);
    chk("t5_err_cleared", 32'(ERR), 32'd0);
    START = 1'b1; START_ADDR = 8'd3;
    UWE = 1'b1; UADDR = 8'd0; UDATA = w(OP_EXEC, 3'd7, 3'd7, 3'd7, 4'h7, 8'h77);
    tick();
    START = 1'b0; UWE = 1'b0;
    wait_done("t5", 20);
    chk_q("t5");
    exp_done(2);
    start(8'd0);
    wait_done("t5_store_kept", 20);
    chk_q("t5_store_kept");

    // Reset mid-program, then restart with a same-cycle write + START.
    load(8'd0, w(OP_EXEC, 3'd1, 3'd0, 3'd0, 4'h2, 8'd1));
    load(8'd1, w(OP_JMP,  3'd5, 3'd5, 3'd5, 4'h5, 8'd0));
    exp_ev(2, 3'd1, 3'd0, 3'd0, 4'h2, 16'h0001);
    start(8'd0);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("t6_rst_outs", outs, 32'd0);
    tick(); tick(); tick();
    chk("t6_idle_outs", outs, 32'd0);
    chk_q("t6_rst");
    load(8'd1, w(OP_HALT, 3'd0, 3'd0, 3'd0, 4'h0, 8'd0));
    exp_ev(2, 3'd2, 3'd3, 3'd4, 4'h5, 16'h009C);
    exp_done(4);
    UWE = 1'b1; UADDR = 8'd0; UDATA = w(OP_EXEC, 3'd2, 3'd3, 3'd4, 4'h5, 8'h9C);
    START = 1'b1; START_ADDR = 8'd0; start_cyc = cyc;
    tick();
    UWE = 1'b0; START = 1'b0;
    wait_done("t6_restart", 20);
    chk("t6_err", 32'(ERR), 32'd0);
    chk_q("t6_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
